ahb_mtx_in_stg_hold: RTL and testbench

//  Bus-matrix input stage for one AHB master port; sits upstream of the output stages and drives their *_op* inputs.

---
 rtl/ahb_mtx_in_stg_hold.sv | 131 +++++++++++++
 tb/tb_ahb_mtx_in_stg_hold.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ahb_mtx_in_stg_hold.sv
// AHB bus-matrix input stage for one master port: presents the master's address
// phase to the output stages, holding it until granted and stalling the master meanwhile.
module ahb_mtx_in_stg_hold #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned USER_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,

    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [USER_W-1:0] HAUSERS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic [3:0]        HMASTERS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,

    input  logic              active_ip,
    input  logic              readyout_ip,
    input  logic              resp_ip,

    output logic              sel_ip,
    output logic [ADDR_W-1:0] addr_ip,
    output logic [USER_W-1:0] auser_ip,
    output logic [1:0]        trans_ip,
    output logic              write_ip,
    output logic [2:0]        size_ip,
    output logic [2:0]        burst_ip,
    output logic [3:0]        prot_ip,
    output logic [3:0]        master_ip,
    output logic              mastlock_ip,
    output logic              held_tran_ip
);

    logic              new_tran;
    logic              accept;
    logic              cancel;
    logic              pend;
    logic              pend_nxt;
    logic              dphase;

    logic [ADDR_W-1:0] hold_addr;
    logic [USER_W-1:0] hold_auser;
    logic [1:0]        hold_trans;
    logic              hold_write;
    logic [2:0]        hold_size;
    logic [2:0]        hold_burst;
    logic [3:0]        hold_prot;
    logic [3:0]        hold_master;
    logic              hold_mastlock;

    assign new_tran = HSELS & HREADYS & HTRANSS[1];
    assign accept   = active_ip & readyout_ip;
    // First ERROR cycle of the previous data phase drops the held transfer.
    assign cancel   = pend & dphase & resp_ip & ~readyout_ip;

    always_comb begin
        pend_nxt = pend;
        if (cancel)
            pend_nxt = 1'b0;
        else if (pend && accept)
            pend_nxt = 1'b0;
        else if (!pend && new_tran && !accept)
            pend_nxt = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend   <= 1'b0;
            dphase <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (!dphase || readyout_ip)
                dphase <= accept & held_tran_ip;
        end
    end

    // Capture registers carry no reset: they are only observed while pend is set.
    always_ff @(posedge HCLK) begin
        if (!pend && new_tran) begin
            hold_addr     <= HADDRS;
            hold_auser    <= HAUSERS;
            hold_trans    <= HTRANSS;
            hold_write    <= HWRITES;
            hold_size     <= HSIZES;
            hold_burst    <= HBURSTS;
            hold_prot     <= HPROTS;
            hold_master   <= HMASTERS;
            hold_mastlock <= HMASTLOCKS;
        end
    end

    assign held_tran_ip = pend | new_tran;

    always_comb begin
        sel_ip      = HSELS;
        addr_ip     = HADDRS;
        auser_ip    = HAUSERS;
        trans_ip    = HTRANSS;
        write_ip    = HWRITES;
        size_ip     = HSIZES;
        burst_ip    = HBURSTS;
        prot_ip     = HPROTS;
        master_ip   = HMASTERS;
        mastlock_ip = HMASTLOCKS;
        if (pend) begin
            sel_ip      = 1'b1;
            addr_ip     = hold_addr;
            auser_ip    = hold_auser;
            trans_ip    = hold_trans;
            write_ip    = hold_write;
            size_ip     = hold_size;
            burst_ip    = hold_burst;
            prot_ip     = hold_prot;
            master_ip   = hold_master;
            mastlock_ip = hold_mastlock;
        end
        if (!held_tran_ip)
            trans_ip = '0;
    end

    assign HREADYOUTS = (dphase ? readyout_ip : 1'b1) & (~pend | accept);
    assign HRESPS     = dphase ? resp_ip : 1'b0;

endmodule

// File: tb/tb_ahb_mtx_in_stg_hold.sv
// Directed-vector bench for ahb_mtx_in_stg_hold: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_ahb_mtx_in_stg_hold;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [31:0] HAUSERS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic [3:0]  HMASTERS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        active_ip;
    logic        readyout_ip;
    logic        resp_ip;
    logic        sel_ip;
    logic [31:0] addr_ip;
    logic [31:0] auser_ip;
    logic [1:0]  trans_ip;
    logic        write_ip;
    logic [2:0]  size_ip;
    logic [2:0]  burst_ip;
    logic [3:0]  prot_ip;
    logic [3:0]  master_ip;
    logic        mastlock_ip;
    logic        held_tran_ip;

    always #5 HCLK = ~HCLK;

    ahb_mtx_in_stg_hold #(.ADDR_W(32), .USER_W(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSELS(HSELS), .HADDRS(HADDRS), .HAUSERS(HAUSERS), .HTRANSS(HTRANSS),
        .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
        .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
        .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip), .trans_ip(trans_ip),
        .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
        .master_ip(master_ip), .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip)
    );

    typedef struct {
        bit          rst, sel, rdy, act, rdyo, resp, lock;
        logic [1:0]  tr;
        logic [31:0] addr;
        bit          e_hro, e_hresp, e_held, e_lock;
        logic [1:0]  e_tr;
        logic [31:0] e_addr;
    } vec_t;

    typedef struct {
        int          row;
        bit          hro, hresp, held, lock;
        logic [1:0]  tr;
        logic [31:0] addr;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic v(input bit rst, input bit sel, input logic [1:0] tr, input bit rdy,
                     input bit act, input bit rdyo, input bit resp, input bit lock,
                     input logic [31:0] addr,
                     input bit e_hro, input bit e_hresp, input bit e_held,
                     input logic [1:0] e_tr, input logic [31:0] e_addr, input bit e_lock);
        vec_t x;
        x.rst = rst; x.sel = sel; x.tr = tr; x.rdy = rdy; x.act = act; x.rdyo = rdyo;
        x.resp = resp; x.lock = lock; x.addr = addr;
        x.e_hro = e_hro; x.e_hresp = e_hresp; x.e_held = e_held; x.e_tr = e_tr;
        x.e_addr = e_addr; x.e_lock = e_lock;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
        end
    endtask

    always @(negedge HCLK) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("HREADYOUTS",   e.row, 32'(HREADYOUTS),   32'(e.hro));
            chk("HRESPS",       e.row, 32'(HRESPS),       32'(e.hresp));
            chk("held_tran_ip", e.row, 32'(held_tran_ip), 32'(e.held));
            chk("trans_ip",     e.row, 32'(trans_ip),     32'(e.tr));
            chk("addr_ip",      e.row, addr_ip,           e.addr);
            chk("mastlock_ip",  e.row, 32'(mastlock_ip),  32'(e.lock));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10;

    initial begin
        //  rst sel tr  rdy act rdyo resp lock addr           hro hresp held tr_ip addr_ip        lock_ip
        v(0, 1, IDL, 1, 0, 1, 0, 0, 32'h0000_0000,   1, 0, 0, IDL, 32'h0000_0000, 0); // R0 reset state
        v(0, 1, NSQ, 1, 1, 1, 0, 0, 32'h2000_0000,   1, 0, 1, NSQ, 32'h2000_0000, 0); // R1 granted at once
        v(0, 1, IDL, 1, 0, 0, 0, 0, 32'h0000_0000,   0, 0, 0, IDL, 32'h0000_0000, 0); // R2 data wait
        v(0, 1, IDL, 1, 0, 0, 0, 0, 32'h0000_0000,   0, 0, 0, IDL, 32'h0000_0000, 0); // R3 data wait
        v(0, 1, IDL, 1, 0, 1, 0, 0, 32'h0000_0000,   1, 0, 0, IDL, 32'h0000_0000, 0); // R4 data done
        v(0, 1, NSQ, 1, 0, 1, 0, 1, 32'h2000_0000,   1, 0, 1, NSQ, 32'h2000_0000, 1); // R5 not granted
        v(0, 1, IDL, 1, 0, 1, 0, 0, 32'hFFFF_FFFF,   0, 0, 1, NSQ, 32'h2000_0000, 1); // R6 held
        v(0, 1, IDL, 1, 0, 1, 0, 0, 32'hFFFF_FFFF,   0, 0, 1, NSQ, 32'h2000_0000, 1); // R7 held
        v(0, 1, IDL, 1, 0, 1, 0, 0, 32'hFFFF_FFFF,   0, 0, 1, NSQ, 32'h2000_0000, 1); // R8 held
        v(0, 1, IDL, 1, 1, 1, 0, 0, 32'hFFFF_FFFF,   1, 0, 1, NSQ, 32'h2000_0000, 1); // R9 held granted
        v(0, 1, IDL, 1, 0, 1, 0, 0, 32'hFFFF_FFFF,   1, 0, 0, IDL, 32'hFFFF_FFFF, 0); // R10 pend cleared
        v(0, 1, NSQ, 1, 1, 1, 0, 0, 32'h3000_0000,   1, 0, 1, NSQ, 32'h3000_0000, 0); // R11
        v(0, 1, NSQ, 1, 0, 0, 0, 0, 32'h4000_0000,   0, 0, 1, NSQ, 32'h4000_0000, 0); // R12 pend + dphase
        v(0, 1, IDL, 1, 0, 0, 1, 0, 32'h0000_0000,   0, 1, 1, NSQ, 32'h4000_0000, 0); // R13 ERROR 1st
        v(0, 1, IDL, 1, 0, 1, 1, 0, 32'h0000_0000,   1, 1, 0, IDL, 32'h0000_0000, 0); // R14 ERROR 2nd
        v(0, 1, IDL, 1, 0, 1, 0, 0, 32'h0000_0000,   1, 0, 0, IDL, 32'h0000_0000, 0); // R15
        v(0, 1, NSQ, 1, 1, 1, 0, 0, 32'h5000_0000,   1, 0, 1, NSQ, 32'h5000_0000, 0); // R16
        v(0, 1, NSQ, 1, 0, 0, 0, 0, 32'h6000_0000,   0, 0, 1, NSQ, 32'h6000_0000, 0); // R17 pend + dphase
        v(1, 1, IDL, 1, 0, 0, 0, 0, 32'h0000_0000,   0, 0, 1, NSQ, 32'h6000_0000, 0); // R18 reset edge
        v(0, 1, IDL, 1, 0, 0, 1, 0, 32'h0000_0000,   1, 0, 0, IDL, 32'h0000_0000, 0); // R19 after reset
        v(0, 1, BSY, 1, 0, 1, 0, 0, 32'h7000_0000,   1, 0, 0, IDL, 32'h7000_0000, 0); // R20 BUSY
        v(0, 1, IDL, 1, 0, 1, 0, 0, 32'h7000_0000,   1, 0, 0, IDL, 32'h7000_0000, 0); // R21 IDLE
        v(0, 0, NSQ, 1, 0, 1, 0, 0, 32'h7000_0000,   1, 0, 0, IDL, 32'h7000_0000, 0); // R22 not selected
        v(0, 1, NSQ, 0, 0, 1, 0, 0, 32'h7000_0000,   1, 0, 0, IDL, 32'h7000_0000, 0); // R23 HREADYS low
        v(0, 1, IDL, 1, 0, 1, 0, 0, 32'h7000_0000,   1, 0, 0, IDL, 32'h7000_0000, 0); // R24 no stray pend

        HRESET = 1'b1; HSELS = 1'b0; HADDRS = '0; HAUSERS = 32'hA5A5_0001; HTRANSS = IDL;
        HWRITES = 1'b0; HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'd3; HMASTERS = 4'd1;
        HMASTLOCKS = 1'b0; HREADYS = 1'b1; active_ip = 1'b0; readyout_ip = 1'b1; resp_ip = 1'b0;
        repeat (2) @(posedge HCLK);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(posedge HCLK);
            #1;
            HRESET      = vecs[i].rst;
            HSELS       = vecs[i].sel;
            HTRANSS     = vecs[i].tr;
            HREADYS     = vecs[i].rdy;
            active_ip   = vecs[i].act;
            readyout_ip = vecs[i].rdyo;
            resp_ip     = vecs[i].resp;
            HMASTLOCKS  = vecs[i].lock;
            HADDRS      = vecs[i].addr;
            e.row  = i;
            e.hro  = vecs[i].e_hro;
            e.hresp = vecs[i].e_hresp;
            e.held = vecs[i].e_held;
            e.tr   = vecs[i].e_tr;
            e.addr = vecs[i].e_addr;
            e.lock = vecs[i].e_lock;
            expq.push_back(e);
        end

        repeat (2) @(posedge HCLK);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
